// File: rtl/pll_rst_ctrl_pkg.sv
// Shared encodings for the PLL reset/lock sequencer.
// State codes are fixed for compatibility with existing tooling.
package pll_rst_ctrl_pkg;

  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  localparam int RETRY_W = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, async active-low reset to zero.
// Reusable for any width of independent level signals.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL areset / lock qualification sequencer.
// Outputs are registered from the next state.
module pll_rst_ctrl
  import pll_rst_ctrl_pkg::*;
#(
  parameter int RST_HOLD     = 100,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RETRY    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               locked,
  input  logic               restart,
  output logic               pll_areset,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int CNT_MAX =
    max3(RST_HOLD, LOCK_STABLE, LOCK_TIMEOUT);
  localparam int CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_END =
    CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] STAB_END =
    CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TOUT_END =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM =
    RETRY_W'(MAX_RETRY);

  logic               locked_s;
  logic [2:0]         state;
  logic [2:0]         nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] nxt_retry;
  logic               cnt_en;

  sync_2ff #(.W(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  always_comb begin
    nxt       = state;
    nxt_retry = retry_cnt;
    unique case (state)
      S_HOLD: begin
        if (cnt == HOLD_END) nxt = S_WAIT;
      end
      S_WAIT: begin
        if (locked_s) begin
          nxt = S_STABLE;
        end else if (cnt == TOUT_END) begin
          if (retry_cnt == RETRY_LIM) begin
            nxt = S_FAIL;
          end else begin
            nxt       = S_HOLD;
            nxt_retry = retry_cnt + RETRY_W'(1);
          end
        end
      end
      S_STABLE: begin
        if (!locked_s) nxt = S_WAIT;
        else if (cnt == STAB_END) nxt = S_RUN;
      end
      S_RUN: begin
        if (!locked_s) nxt = S_HOLD;
      end
      S_FAIL: begin
        nxt = S_FAIL;
      end
      default: begin
        nxt = S_HOLD;
      end
    endcase
    if (nxt == S_RUN) nxt_retry = '0;
    // restart overrides whatever the state decided
    if (restart) begin
      nxt       = S_HOLD;
      nxt_retry = '0;
    end
  end

  assign cnt_en = (state == S_HOLD) ||
                  (state == S_WAIT) ||
                  (state == S_STABLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HOLD;
      cnt        <= '0;
      retry_cnt  <= '0;
      pll_areset <= 1'b1;
      sys_rst_n  <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state     <= nxt;
      retry_cnt <= nxt_retry;
      if (restart || (nxt != state) || !cnt_en)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      pll_areset <= (nxt == S_HOLD) || (nxt == S_FAIL);
      sys_rst_n  <= (nxt == S_RUN);
      ready      <= (nxt == S_RUN);
      fail       <= (nxt == S_FAIL);
    end
  end

endmodule
